systolic_mm_engine: RTL and testbench

Parametrised, self-sequencing SIZE×SIZE matrix-multiply engine: the next-generation systolic array with signed/unsigned mode, built-in operand skewing, bubble-tolerant streaming and a valid/ready result handshake. It accepts C = A·B one k-slice per beat (column k of A, row k of B), skews operands internally, accumulates in an output-stationary PE grid and holds the full C matrix until consumed. It sits between the operand fetch logic and the result writeback path.

---
 rtl/systolic_pkg.sv | 35 +++
 rtl/systolic_pe_acc.sv | 95 +++++++++
 rtl/systolic_mm_engine.sv | 233 +++++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// ----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic matrix-multiply engine:
//   - state_e   : sequencer states (IDLE, LOAD, DRAIN, DONE)
//   - clog2     : ceiling log2 used for counter and accumulator widths
//   - acc_width : accumulator width derived from operand width and array size
// ----------------------------------------------------------------------------
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 32'sd0;
      rem    = value - 32'sd1;
      while (rem > 32'sd0) begin
         result = result + 32'sd1;
         rem    = rem >>> 1;
      end
      return result;
   endfunction

   // A full-width product summed SIZE times never exceeds this width.
   function automatic int acc_width(input int data_width, input int size);
      return (32'sd2 * data_width) + clog2(size);
   endfunction

endpackage

// File: rtl/systolic_pe_acc.sv
// ----------------------------------------------------------------------------
// systolic_pe_acc
// One output-stationary processing element.
//   clk, rst              : clock, asynchronous active-low reset
//   clear                 : synchronous accumulator clear (wins over a MAC)
//   a_in/a_in_valid       : operand arriving from the left
//   b_in/b_in_valid       : operand arriving from above
//   a_out/a_out_valid     : a_in delayed one cycle, towards the right
//   b_out/b_out_valid     : b_in delayed one cycle, towards below
//   acc                   : registered running sum of a*b
// ----------------------------------------------------------------------------
module systolic_pe_acc #(
   parameter int DATA_WIDTH = 10,
   parameter int ACC_WIDTH  = 22,
   parameter bit SIGNED     = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic                  a_in_valid,
   input  logic [DATA_WIDTH-1:0] b_in,
   input  logic                  b_in_valid,
   output logic [DATA_WIDTH-1:0] a_out,
   output logic                  a_out_valid,
   output logic [DATA_WIDTH-1:0] b_out,
   output logic                  b_out_valid,
   output logic [ACC_WIDTH-1:0]  acc
);

   localparam int PW = 2 * DATA_WIDTH;

   logic [PW-1:0]         a_ext_s;
   logic [PW-1:0]         b_ext_s;
   logic [PW-1:0]         prod_s;
   logic [ACC_WIDTH-1:0]  prod_acc_s;
   logic                  ext_bit_s;

   logic [DATA_WIDTH-1:0] a_d, a_q, b_d, b_q;
   logic                  a_v_d, a_v_q, b_v_d, b_v_q;
   logic [ACC_WIDTH-1:0]  acc_d, acc_q;

   // Product and next-state computation; operands are extended to the full
   // product width so the low PW bits of the multiply are exact in either mode.
   always_comb begin
      if (SIGNED) begin
         a_ext_s = {{DATA_WIDTH{a_in[DATA_WIDTH-1]}}, a_in};
         b_ext_s = {{DATA_WIDTH{b_in[DATA_WIDTH-1]}}, b_in};
      end else begin
         a_ext_s = {{DATA_WIDTH{1'b0}}, a_in};
         b_ext_s = {{DATA_WIDTH{1'b0}}, b_in};
      end
      prod_s     = a_ext_s * b_ext_s;
      ext_bit_s  = SIGNED ? prod_s[PW-1] : 1'b0;
      prod_acc_s = {{(ACC_WIDTH-PW){ext_bit_s}}, prod_s};

      a_d   = a_in;
      a_v_d = a_in_valid;
      b_d   = b_in;
      b_v_d = b_in_valid;

      // A bubble on either side means the pair is not a real product.
      if (clear) begin
         acc_d = '0;
      end else if (a_in_valid && b_in_valid) begin
         acc_d = acc_q + prod_acc_s;
      end else begin
         acc_d = acc_q;
      end
   end

   // Pass-through and accumulator registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q   <= '0;
         a_v_q <= 1'b0;
         b_q   <= '0;
         b_v_q <= 1'b0;
         acc_q <= '0;
      end else begin
         a_q   <= a_d;
         a_v_q <= a_v_d;
         b_q   <= b_d;
         b_v_q <= b_v_d;
         acc_q <= acc_d;
      end
   end

   assign a_out       = a_q;
   assign a_out_valid = a_v_q;
   assign b_out       = b_q;
   assign b_out_valid = b_v_q;
   assign acc         = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// ----------------------------------------------------------------------------
// systolic_mm_engine
// SIZE x SIZE output-stationary matrix multiply, C = A * B, fed one k-slice
// per beat (column k of A, row k of B).
//   clk, rst             : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand beat handshake (ready in IDLE and LOAD)
//   a_col                : A[i][k] at [i*DATA_WIDTH +: DATA_WIDTH]
//   b_row                : B[k][j] at [j*DATA_WIDTH +: DATA_WIDTH]
//   out_valid / out_ready: result handshake; c is held until taken
//   c                    : C[i][j] at [(i*SIZE+j)*ACC_WIDTH +: ACC_WIDTH]
//   busy                 : high in LOAD, DRAIN and DONE
// ----------------------------------------------------------------------------
module systolic_mm_engine
   import systolic_pkg::*;
#(
   parameter  int SIZE       = 3,
   parameter  int DATA_WIDTH = 10,
   parameter  bit SIGNED     = 1'b0,
   localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, SIZE)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [SIZE*DATA_WIDTH-1:0]     a_col,
   input  logic [SIZE*DATA_WIDTH-1:0]     b_row,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [SIZE*SIZE*ACC_WIDTH-1:0] c,
   output logic                           busy
);

   localparam int DW  = DATA_WIDTH;
   localparam int BCW = clog2(SIZE + 1);
   localparam int DCW = clog2(2 * SIZE + 1);
   localparam logic [BCW-1:0] LAST_BEAT  = BCW'(SIZE - 1);
   localparam logic [DCW-1:0] LAST_DRAIN = DCW'(2 * SIZE - 1);
   localparam logic [BCW-1:0] ONE_BEAT   = BCW'(32'd1);

   logic accept_s;
   logic clear_s;

   // Operand buses between PEs: a flows along a row, b down a column.
   logic [DW-1:0] a_bus_s   [SIZE][SIZE+1];
   logic          a_bus_v_s [SIZE][SIZE+1];
   logic [DW-1:0] b_bus_s   [SIZE+1][SIZE];
   logic          b_bus_v_s [SIZE+1][SIZE];

   state_e         state_d, state_q;
   logic [BCW-1:0] beat_cnt_d, beat_cnt_q;
   logic [DCW-1:0] drain_cnt_d, drain_cnt_q;
   logic           in_ready_d, in_ready_q;
   logic           out_valid_d, out_valid_q;
   logic           busy_d, busy_q;

   assign accept_s = in_valid && ((state_q == IDLE) || (state_q == LOAD));
   // Beat 0 wipes the previous result; its own products land a cycle later.
   assign clear_s  = in_valid && (state_q == IDLE);

   // Row i of A: one capture stage plus i skew stages.
   for (genvar i = 0; i < SIZE; i++) begin : g_a_skew
      logic [DW-1:0] sr_d [i+1];
      logic [DW-1:0] sr_q [i+1];
      logic          v_d  [i+1];
      logic          v_q  [i+1];

      // Shift the row operand and its valid one stage per cycle.
      always_comb begin
         sr_d[0] = a_col[i*DW +: DW];
         v_d[0]  = accept_s;
         for (int k = 1; k <= i; k++) begin
            sr_d[k] = sr_q[k-1];
            v_d[k]  = v_q[k-1];
         end
      end

      // Skew registers for row i.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int k = 0; k <= i; k++) begin
               sr_q[k] <= '0;
               v_q[k]  <= 1'b0;
            end
         end else begin
            sr_q <= sr_d;
            v_q  <= v_d;
         end
      end

      assign a_bus_s[i][0]   = sr_q[i];
      assign a_bus_v_s[i][0] = v_q[i];
   end

   // Column j of B: one capture stage plus j skew stages.
   for (genvar j = 0; j < SIZE; j++) begin : g_b_skew
      logic [DW-1:0] sr_d [j+1];
      logic [DW-1:0] sr_q [j+1];
      logic          v_d  [j+1];
      logic          v_q  [j+1];

      // Shift the column operand and its valid one stage per cycle.
      always_comb begin
         sr_d[0] = b_row[j*DW +: DW];
         v_d[0]  = accept_s;
         for (int k = 1; k <= j; k++) begin
            sr_d[k] = sr_q[k-1];
            v_d[k]  = v_q[k-1];
         end
      end

      // Skew registers for column j.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int k = 0; k <= j; k++) begin
               sr_q[k] <= '0;
               v_q[k]  <= 1'b0;
            end
         end else begin
            sr_q <= sr_d;
            v_q  <= v_d;
         end
      end

      assign b_bus_s[0][j]   = sr_q[j];
      assign b_bus_v_s[0][j] = v_q[j];
   end

   for (genvar i = 0; i < SIZE; i++) begin : g_row
      for (genvar j = 0; j < SIZE; j++) begin : g_col
         systolic_pe_acc #(
            .DATA_WIDTH (DW),
            .ACC_WIDTH  (ACC_WIDTH),
            .SIGNED     (SIGNED)
         ) u_pe (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear_s),
            .a_in        (a_bus_s[i][j]),
            .a_in_valid  (a_bus_v_s[i][j]),
            .b_in        (b_bus_s[i][j]),
            .b_in_valid  (b_bus_v_s[i][j]),
            .a_out       (a_bus_s[i][j+1]),
            .a_out_valid (a_bus_v_s[i][j+1]),
            .b_out       (b_bus_s[i+1][j]),
            .b_out_valid (b_bus_v_s[i+1][j]),
            .acc         (c[(i*SIZE+j)*ACC_WIDTH +: ACC_WIDTH])
         );
      end
   end

   // Sequencer next state; the drain counter covers the skew plus grid depth.
   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      drain_cnt_d = drain_cnt_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               if (SIZE == 1) begin
                  state_d    = DRAIN;
                  beat_cnt_d = '0;
               end else begin
                  state_d    = LOAD;
                  beat_cnt_d = ONE_BEAT;
               end
               drain_cnt_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (accept_s) begin
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d     = DRAIN;
                  beat_cnt_d  = '0;
                  drain_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + ONE_BEAT;
               end
            end else begin
               state_d = LOAD;
            end
         end
         DRAIN: begin
            if (drain_cnt_q == LAST_DRAIN) begin
               state_d     = DONE;
               drain_cnt_d = '0;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_valid_q && out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d     = IDLE;
            beat_cnt_d  = '0;
            drain_cnt_d = '0;
         end
      endcase
      in_ready_d  = (state_d == IDLE) || (state_d == LOAD);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // Sequencer state, counters and registered handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         beat_cnt_q  <= '0;
         drain_cnt_q <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// ----------------------------------------------------------------------------
// tb_systolic_mm_engine
// Directed bench for a SIZE=3, DATA_WIDTH=8 engine. An unsigned and a signed
// instance share the same stimulus so both arithmetic modes are exercised.
// ----------------------------------------------------------------------------
module tb_systolic_mm_engine;

   localparam int SIZE = 3;
   localparam int DW   = 8;
   localparam int ACC  = 18;   // 2*8 + clog2(3)
   localparam int CW   = SIZE * SIZE * ACC;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             out_ready;
   logic [SIZE*DW-1:0] a_col;
   logic [SIZE*DW-1:0] b_row;
   logic             in_ready_u, out_valid_u, busy_u;
   logic             in_ready_s, out_valid_s, busy_s;
   logic [CW-1:0]    c_u, c_s;

   int checks;
   int failures;
   int mat_a [SIZE][SIZE];
   int mat_b [SIZE][SIZE];

   systolic_mm_engine #(.SIZE(SIZE), .DATA_WIDTH(DW), .SIGNED(1'b0)) u_dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
      .a_col(a_col), .b_row(b_row), .out_valid(out_valid_u),
      .out_ready(out_ready), .c(c_u), .busy(busy_u)
   );

   systolic_mm_engine #(.SIZE(SIZE), .DATA_WIDTH(DW), .SIGNED(1'b1)) u_dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .a_col(a_col), .b_row(b_row), .out_valid(out_valid_s),
      .out_ready(out_ready), .c(c_s), .busy(busy_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [ACC-1:0] elem(input logic [CW-1:0] cv, input int idx);
      return cv[idx*ACC +: ACC];
   endfunction

   task automatic set_identity_b();
      for (int i = 0; i < SIZE; i++)
         for (int j = 0; j < SIZE; j++) begin
            mat_a[i][j] = (i == j) ? 1 : 0;
            mat_b[i][j] = i * SIZE + j + 1;
         end
   endtask

   task automatic set_const(input int av, input int bv);
      for (int i = 0; i < SIZE; i++)
         for (int j = 0; j < SIZE; j++) begin
            mat_a[i][j] = av;
            mat_b[i][j] = bv;
         end
   endtask

   // Sends the k-slices of mat_a/mat_b with 'gap' idle cycles between beats.
   task automatic send_matrix(input int gap);
      for (int k = 0; k < SIZE; k++) begin
         for (int i = 0; i < SIZE; i++) begin
            a_col[i*DW +: DW] = DW'(mat_a[i][k]);
            b_row[i*DW +: DW] = DW'(mat_b[k][i]);
         end
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (k != SIZE - 1) repeat (gap) begin @(posedge clk); #1; end
      end
   endtask

   // Cycles from the final beat edge until out_valid is seen; -1 on timeout.
   task automatic wait_result(output int lat);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (out_valid_u) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic handshake(input string name);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid_u !== 1'b0 || in_ready_u !== 1'b1) begin
         failures++;
         $display("FAIL %s_handshake: out_valid=%b in_ready=%b, required 0 and 1",
                  name, out_valid_u, in_ready_u);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_col = '0; b_row = '0;
      repeat (2) @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready_u !== 1'b1 || in_ready_s !== 1'b1) begin
         failures++; $display("FAIL reset_in_ready: got %b/%b required 1", in_ready_u, in_ready_s);
      end
      checks++;
      if (out_valid_u !== 1'b0 || out_valid_s !== 1'b0) begin
         failures++; $display("FAIL reset_out_valid: got %b/%b required 0", out_valid_u, out_valid_s);
      end
      checks++;
      if (busy_u !== 1'b0 || busy_s !== 1'b0) begin
         failures++; $display("FAIL reset_busy: got %b/%b required 0", busy_u, busy_s);
      end
      checks++;
      if (c_u !== '0 || c_s !== '0) begin
         failures++; $display("FAIL reset_c: got %h / %h required 0", c_u, c_s);
      end
   endtask

   task automatic test_identity();
      int exp_c [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      int lat;
      set_identity_b();
      send_matrix(0);
      checks++;
      if (busy_u !== 1'b1 || in_ready_u !== 1'b0) begin
         failures++; $display("FAIL identity_drain_flags: busy=%b in_ready=%b required 1 and 0", busy_u, in_ready_u);
      end
      wait_result(lat);
      checks++;
      if (lat !== 6) begin
         failures++; $display("FAIL identity_latency: got %0d cycles required 6", lat);
      end
      for (int e = 0; e < 9; e++) begin
         checks++;
         if (elem(c_u, e) !== 18'(exp_c[e]) || elem(c_s, e) !== 18'(exp_c[e])) begin
            failures++;
            $display("FAIL identity_c[%0d]: got %0d/%0d required %0d", e, elem(c_u, e), elem(c_s, e), exp_c[e]);
         end
      end
      handshake("identity");
   endtask

   task automatic test_bubbles();
      int exp_c [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      int lat;
      set_identity_b();
      send_matrix(2);
      wait_result(lat);
      checks++;
      if (lat !== 6) begin
         failures++; $display("FAIL bubbles_latency: got %0d cycles required 6", lat);
      end
      for (int e = 0; e < 9; e++) begin
         checks++;
         if (elem(c_u, e) !== 18'(exp_c[e])) begin
            failures++; $display("FAIL bubbles_c[%0d]: got %0d required %0d", e, elem(c_u, e), exp_c[e]);
         end
      end
      handshake("bubbles");
   endtask

   task automatic test_max_unsigned();
      int lat;
      set_const(255, 255);
      send_matrix(0);
      wait_result(lat);
      checks++;
      if (lat !== 6) begin
         failures++; $display("FAIL max_latency: got %0d cycles required 6", lat);
      end
      for (int e = 0; e < 9; e++) begin
         checks++;
         // unsigned: 3*255*255; signed view of 0xFF is -1, so 3*(-1)*(-1)
         if (elem(c_u, e) !== 18'd195075 || elem(c_s, e) !== 18'd3) begin
            failures++; $display("FAIL max_c[%0d]: got %0d/%0d required 195075/3", e, elem(c_u, e), elem(c_s, e));
         end
      end
      handshake("max");
   endtask

   task automatic test_signed();
      int lat;
      set_const(128, 127);
      send_matrix(0);
      wait_result(lat);
      checks++;
      if (lat !== 6 || out_valid_s !== 1'b1) begin
         failures++; $display("FAIL signed_latency: got %0d cycles (out_valid_s=%b) required 6", lat, out_valid_s);
      end
      for (int e = 0; e < 9; e++) begin
         checks++;
         // -48768 as 18-bit two's complement is 213376; unsigned 3*128*127 = 48768
         if (elem(c_s, e) !== 18'd213376 || elem(c_u, e) !== 18'd48768) begin
            failures++; $display("FAIL signed_c[%0d]: got %h/%0d required 34180/48768", e, elem(c_s, e), elem(c_u, e));
         end
      end
      handshake("signed");
   endtask

   task automatic test_hold_and_residue();
      int exp_c [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      int exp_r [9] = '{12, 15, 18, 12, 15, 18, 12, 15, 18};
      int lat;
      set_identity_b();
      send_matrix(0);
      wait_result(lat);
      a_col = {SIZE{8'h05}};
      b_row = {SIZE{8'h07}};
      in_valid = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid_u !== 1'b1 || in_ready_u !== 1'b0 || busy_u !== 1'b1) begin
            failures++; $display("FAIL hold_flags[%0d]: out_valid=%b in_ready=%b busy=%b required 1 0 1",
                                 n, out_valid_u, in_ready_u, busy_u);
         end
         for (int e = 0; e < 9; e++) begin
            checks++;
            if (elem(c_u, e) !== 18'(exp_c[e])) begin
               failures++; $display("FAIL hold_c[%0d][%0d]: got %0d required %0d", n, e, elem(c_u, e), exp_c[e]);
            end
         end
      end
      in_valid = 1'b0;
      handshake("hold");
      set_const(1, 0);
      for (int i = 0; i < SIZE; i++)
         for (int j = 0; j < SIZE; j++) mat_b[i][j] = i * SIZE + j + 1;
      send_matrix(0);
      wait_result(lat);
      checks++;
      if (lat !== 6) begin
         failures++; $display("FAIL residue_latency: got %0d cycles required 6", lat);
      end
      for (int e = 0; e < 9; e++) begin
         checks++;
         if (elem(c_u, e) !== 18'(exp_r[e])) begin
            failures++; $display("FAIL residue_c[%0d]: got %0d required %0d", e, elem(c_u, e), exp_r[e]);
         end
      end
      handshake("residue");
   endtask

   task automatic test_reset_mid();
      int exp_c [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      int lat;
      set_const(1, 1);
      for (int k = 0; k < 2; k++) begin
         a_col = {SIZE{8'h01}};
         b_row = {SIZE{8'h01}};
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (busy_u !== 1'b1) begin
         failures++; $display("FAIL midreset_busy_before: got %b required 1", busy_u);
      end
      rst = 1'b0;
      #2;
      checks++;
      if (in_ready_u !== 1'b1 || out_valid_u !== 1'b0 || busy_u !== 1'b0) begin
         failures++; $display("FAIL midreset_flags: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                              in_ready_u, out_valid_u, busy_u);
      end
      checks++;
      if (c_u !== '0) begin
         failures++; $display("FAIL midreset_c: got %h required 0", c_u);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      set_identity_b();
      send_matrix(0);
      wait_result(lat);
      checks++;
      if (lat !== 6) begin
         failures++; $display("FAIL midreset_latency: got %0d cycles required 6", lat);
      end
      for (int e = 0; e < 9; e++) begin
         checks++;
         if (elem(c_u, e) !== 18'(exp_c[e])) begin
            failures++; $display("FAIL midreset_c[%0d]: got %0d required %0d", e, elem(c_u, e), exp_c[e]);
         end
      end
      handshake("midreset");
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_identity();
      test_bubbles();
      test_max_unsigned();
      test_signed();
      test_hold_and_residue();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
